alu_accum_seq: RTL and testbench

- Parameterised-width accumulator ALU with a control FSM. Operand loading, accumulate-in-place execution, overflow trapping and a multi-cycle shift-add multiplier are all handled inside the block.
- Successor to the fixed 8-bit accumulator ALU. It adds WIDTH generalisation, encoded opcodes, a go/busy/done handshake, and a sticky error that must be explicitly cleared.
- Sits between the operand input registers/switch logic and the display/output path.

---
 rtl/alu_accum_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_accum_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accum_seq.sv
// Accumulator ALU with go/busy/done handshake, sticky overflow error and a
// radix-2 shift-add multiplier. acc is both an operand and the destination;
// b is only ever written by load/clear.
module alu_accum_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [2:0]       op,
  input  logic             go,
  output logic [WIDTH-1:0] acc_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       state
);

  localparam logic [2:0] stOff   = 3'd0;
  localparam logic [2:0] stReady = 3'd1;
  localparam logic [2:0] stRun   = 3'd2;
  localparam logic [2:0] stMul   = 3'd3;
  localparam logic [2:0] stError = 3'd4;

  localparam logic [2:0] opAnd  = 3'd0;
  localparam logic [2:0] opOr   = 3'd1;
  localparam logic [2:0] opXor  = 3'd2;
  localparam logic [2:0] opNot  = 3'd3;
  localparam logic [2:0] opAdd  = 3'd4;
  localparam logic [2:0] opSub  = 3'd5;
  localparam logic [2:0] opMul  = 3'd6;
  localparam logic [2:0] opPass = 3'd7;

  localparam logic [1:0] selLoad  = 2'b01;
  localparam logic [1:0] selClear = 2'b10;

  logic [WIDTH-1:0]   acc, b;
  logic [2:0]         opLatch;
  logic [CNT_W-1:0]   mulCnt;
  logic [2*WIDTH-1:0] mcand, prod, prodNext;
  logic [WIDTH-1:0]   mplier;
  logic               mulLast;

  logic [WIDTH-1:0]   runRes;
  logic               runOvf;
  logic [WIDTH:0]     addWide;

  assign acc_out = acc;
  assign busy    = (state == stRun) || (state == stMul);

  // Single-cycle result of the latched op; overflow only for ADD/SUB
  always_comb begin
    runRes  = acc;
    runOvf  = 1'b0;
    addWide = {1'b0, acc} + {1'b0, b};
    case (opLatch)
      opAnd:  runRes = acc & b;
      opOr:   runRes = acc | b;
      opXor:  runRes = acc ^ b;
      opNot:  runRes = ~acc;
      opAdd: begin
        runRes = addWide[WIDTH-1:0];
        runOvf = addWide[WIDTH];
      end
      opSub: begin
        runRes = acc - b;
        runOvf = (acc < b);
      end
      opPass: runRes = b;
      default: runRes = acc;
    endcase
  end

  // One shift-add iteration: add the shifted multiplicand when the current
  // multiplier LSB is set. The final iteration writes straight from prodNext.
  assign prodNext = prod + (mplier[0] ? mcand : {(2*WIDTH){1'b0}});
  assign mulLast  = (mulCnt == CNT_W'(WIDTH - 1));

  // Control FSM and datapath registers; rst beats on, on beats everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= stReady;
      acc     <= '0;
      b       <= '0;
      error   <= 1'b0;
      done    <= 1'b0;
      opLatch <= '0;
      mulCnt  <= '0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      done <= 1'b0;
      if (!on) begin
        // Abort anything in flight; acc, b and error are kept
        state <= stOff;
      end else begin
        case (state)
          stOff: state <= stReady;
          stReady: begin
            if (in_sel == selLoad) begin
              acc <= num1;
              b   <= num2;
            end else if (in_sel == selClear) begin
              acc   <= '0;
              b     <= '0;
              error <= 1'b0;
            end else if (go) begin
              opLatch <= op;
              if (op == opMul) begin
                mulCnt <= '0;
                prod   <= '0;
                mcand  <= {{WIDTH{1'b0}}, acc};
                mplier <= b;
                state  <= stMul;
              end else begin
                state <= stRun;
              end
            end
          end
          stRun: begin
            acc  <= runRes;
            done <= 1'b1;
            if (runOvf) begin
              error <= 1'b1;
              state <= stError;
            end else begin
              state <= stReady;
            end
          end
          stMul: begin
            prod   <= prodNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            mulCnt <= mulCnt + CNT_W'(1);
            if (mulLast) begin
              acc  <= prodNext[WIDTH-1:0];
              done <= 1'b1;
              if (|prodNext[2*WIDTH-1:WIDTH]) begin
                error <= 1'b1;
                state <= stError;
              end else begin
                state <= stReady;
              end
            end
          end
          stError: begin
            if (in_sel == selClear) begin
              acc   <= '0;
              b     <= '0;
              error <= 1'b0;
              state <= stReady;
            end
          end
          default: state <= stReady;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_accum_seq.sv
// Bench for alu_accum_seq: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a behavioural model.
module tb_alu_accum_seq;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         on = 1'b1;
  logic [1:0]   in_sel = 2'b00;
  logic [W-1:0] num1 = '0;
  logic [W-1:0] num2 = '0;
  logic [2:0]   op = 3'd0;
  logic         go = 1'b0;
  logic [W-1:0] acc_out;
  logic         busy, done, error;
  logic [2:0]   state;

  int total = 0;
  int bad   = 0;
  bit chkEn = 1'b0;

  alu_accum_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .num1(num1), .num2(num2),
    .op(op), .go(go), .acc_out(acc_out), .busy(busy), .done(done),
    .error(error), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural model: values as they stand after each rising edge.
  // 0 off, 1 ready, 2 executing a one-cycle op, 3 multiplying, 4 error
  int mSt, mAcc, mB, mErr, mDone, mOp, mProd, mLeft;
  always @(posedge clk) begin
    int r;
    bit ov;
    mDone = 0;
    if (rst) begin
      mSt = 1; mAcc = 0; mB = 0; mErr = 0; mOp = 0; mLeft = 0;
    end else if (!on) begin
      mSt = 0;
    end else begin
      case (mSt)
        0: mSt = 1;
        1: begin
          if (in_sel == 2'b01) begin
            mAcc = num1; mB = num2;
          end else if (in_sel == 2'b10) begin
            mAcc = 0; mB = 0; mErr = 0;
          end else if (go) begin
            if (op == 3'd6) begin
              mProd = mAcc * mB; mLeft = W; mSt = 3;
            end else begin
              mOp = op; mSt = 2;
            end
          end
        end
        2: begin
          case (mOp)
            0: r = mAcc & mB;
            1: r = mAcc | mB;
            2: r = mAcc ^ mB;
            3: r = ~mAcc;
            4: r = mAcc + mB;
            5: r = mAcc - mB;
            default: r = mB;
          endcase
          ov = (mOp == 4 && r > MASK) || (mOp == 5 && mAcc < mB);
          mAcc = r & MASK;
          mDone = 1;
          if (ov) begin mErr = 1; mSt = 4; end else mSt = 1;
        end
        3: begin
          mLeft = mLeft - 1;
          if (mLeft == 0) begin
            mAcc = mProd & MASK;
            mDone = 1;
            if ((mProd >> W) != 0) begin mErr = 1; mSt = 4; end else mSt = 1;
          end
        end
        default: begin
          if (in_sel == 2'b10) begin
            mAcc = 0; mB = 0; mErr = 0; mSt = 1;
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (chkEn) begin
      chk("acc", acc_out, mAcc);
      chk("done", done, mDone);
      chk("error", error, mErr);
      chk("state", state, mSt);
      chk("busy", busy, (mSt == 2 || mSt == 3) ? 1 : 0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input int a, input int bb);
    in_sel = 2'b01; num1 = W'(a); num2 = W'(bb);
    step();
    in_sel = 2'b00;
  endtask

  task automatic clear();
    in_sel = 2'b10;
    step();
    in_sel = 2'b00;
  endtask

  // Issue one go and wait (bounded) for done; checks latency and acc_out
  task automatic runOp(input string name, input int o, input int expLat,
                       input int expAcc, input int expErr);
    int cnt;
    op = 3'(o); go = 1'b1;
    step();
    go = 1'b0;
    cnt = 0;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    chk({name, "_lat"}, cnt, expLat);
    chk({name, "_acc"}, acc_out, expAcc);
    chk({name, "_err"}, error, expErr);
  endtask

  initial begin
    step();
    chkEn = 1'b1;
    chk("rst_state", state, 1);
    chk("rst_acc", acc_out, 0);
    rst = 1'b0;
    step();

    // Chained ADDs
    load(5, 3);
    runOp("add1", 4, 1, 8, 0);
    runOp("add2", 4, 1, 11, 0);
    runOp("add3", 4, 1, 14, 0);
    step();
    chk("add_state", state, 1);

    // ADD overflow traps, ERROR ignores go and load until cleared
    load(200, 100);
    runOp("addov", 4, 1, 8'h2C, 1);
    step();
    chk("ov_state", state, 4);
    go = 1'b1; op = 3'd4;
    step();
    go = 1'b0;
    load(1, 1);
    chk("ov_hold", acc_out, 8'h2C);
    clear();
    chk("clr_acc", acc_out, 0);
    chk("clr_err", error, 0);
    chk("clr_state", state, 1);

    // SUB borrow, then logic ops
    load(3, 5);
    runOp("sub", 5, 1, 8'hFE, 1);
    clear();
    load(8'hF0, 8'h3C);
    runOp("and", 0, 1, 8'h30, 0);
    runOp("not", 3, 1, 8'hCF, 0);

    // Multiplier
    load(15, 17);
    runOp("mul", 6, W, 8'hFF, 0);
    load(16, 16);
    runOp("mulov", 6, W, 8'h00, 1);
    clear();

    // rst mid-multiply
    load(15, 17);
    op = 3'd6; go = 1'b1;
    step();
    go = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_state", state, 1);
    chk("mrst_acc", acc_out, 0);
    chk("mrst_done", done, 0);

    // on=0 mid-multiply
    load(15, 17);
    op = 3'd6; go = 1'b1;
    step();
    go = 1'b0;
    repeat (3) step();
    on = 1'b0;
    step();
    chk("moff_state", state, 0);
    chk("moff_acc", acc_out, 15);
    chk("moff_done", done, 0);
    on = 1'b1;
    step();
    chk("on_state", state, 1);

    // load wins over go in the same cycle
    in_sel = 2'b01; num1 = 8'd9; num2 = 8'd2; go = 1'b1; op = 3'd4;
    step();
    in_sel = 2'b00; go = 1'b0;
    chk("prio_acc", acc_out, 9);
    chk("prio_done", done, 0);
    chk("prio_state", state, 1);
    runOp("prio_add", 4, 1, 11, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      on     = ($urandom_range(0, 49) != 0);
      in_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      go     = ($urandom_range(0, 2) == 0);
      op     = 3'($urandom_range(0, 7));
      num1   = W'($urandom);
      num2   = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      step();
    end
    rst = 1'b0; on = 1'b1; go = 1'b0; in_sel = 2'b00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
